rv32i_multicycle_ctrl: RTL and testbench
========================================

// Module: rv32i_multicycle_ctrl
// PURPOSE
//  Multi-cycle main controller for the RV32I core.
//  Sequences the shared ALU / ALU-control datapath, IR, PC and memory port through fetch, decode,
//  execute, memory and writeback, one instruction at a time. Drives Alu_op, operand muxes and writeback controls.
//  Also counts retired instructions and traps on illegal opcodes or memory timeout.
// PARAMETERS
//  MEM_TIMEOUT  16  max waiting cycles for mem_ready before bus-error trap (>=1)
//  CNT_W        32  width of retired-instruction counter
// PORTS
//  clk         in   1      clock, rising edge
//  rst_n       in   1      reset, asynchronous, active-low
//  run         in   1      level; 1 = execute instructions
//  opcode      in   7      IR[6:0], stable from DECODE until next FETCH
//  funct3      in   3      IR[14:12]
//  zero        in   1      ALU zero flag
//  mem_ready   in   1      memory ack for current mem_req
//  mem_req     out  1      memory access request, held until mem_ready
//  mem_we      out  1      1 = store
//  ir_write    out  1      latch fetched word into IR
//  pc_write    out  1      update PC
//  pc_src      out  2      00 ALU result (pc+4); 01 ALUOut target; 10 ALU result & ~1 (jalr)
//  alu_op      out  2      00 add; 01 sub (compare); 10 funct-decoded
//  alu_src_a   out  2      00 PC (old_pc outside FETCH); 01 rs1; 10 constant 0
//  alu_src_b   out  2      00 rs2; 01 imm; 10 constant 4
//  reg_write   out  1      register file write enable
//  wb_sel      out  2      00 ALUOut; 01 mem data; 10 pc+4
//  state_o     out  4      current state encoding (debug)
//  trap        out  1      sticky trap flag
//  trap_cause  out  2      00 none; 01 illegal instr; 10 bus timeout
//  instret     out  CNT_W  retired-instruction count, wraps mod 2^CNT_W
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, every output 0, timeout counter 0, instret 0. Takes effect mid-instruction.
//  - Outputs are Moore decodes of state; unlisted outputs are 0. Exceptions: ir_write/pc_write in FETCH, and pc_write in BRANCH.
//  - States (state_o encoding):
//      IDLE=0 FETCH=1 DECODE=2 EXEC_R=3 EXEC_I=4 EXEC_U=5 MEM_ADDR=6 MEM_RD=7 MEM_WR=8
//      WB_ALU=9 WB_MEM=10 BRANCH=11 JAL=12 JALR=13 TRAP=14.
//  - IDLE: outputs 0; ->FETCH when run=1.
//  - FETCH: mem_req=1, a=00, b=10, op=00.
//      While mem_ready=0, hold. In the mem_ready=1 cycle: ir_write=1, pc_write=1, pc_src=00; ->DECODE.
//  - DECODE: a=00, b=01, op=00 (branch/jal target into ALUOut). Dispatch on opcode:
//      0110011->EXEC_R; 0010011->EXEC_I; 0110111/0010111->EXEC_U; 0000011/0100011->MEM_ADDR;
//      1100011 with funct3 000/001->BRANCH; 1101111->JAL; 1100111->JALR; anything else->TRAP, cause 01.
//  - EXEC_R: a=01, b=00, op=10. EXEC_I: a=01, b=01, op=10.
//      EXEC_U: b=01, op=00, a=10 if opcode[5] (LUI) else 00 (AUIPC). All three ->WB_ALU.
//  - MEM_ADDR: a=01, b=01, op=00; ->MEM_RD if opcode[5]=0 else MEM_WR.
//  - MEM_RD: mem_req=1; ->WB_MEM on mem_ready.
//      MEM_WR: mem_req=1, mem_we=1; retires on mem_ready.
//  - WB_ALU: reg_write=1, wb_sel=00. WB_MEM: reg_write=1, wb_sel=01. Both retire.
//  - BRANCH: a=01, b=00, op=01, pc_src=01.
//      pc_write=(funct3==000 & zero) | (funct3==001 & ~zero). Retires.
//  - JAL: reg_write=1, wb_sel=10, pc_write=1, pc_src=01; retires.
//      JALR: a=01, b=01, op=00, reg_write=1, wb_sel=10, pc_write=1, pc_src=10; retires.
//  - Retire: instret+=1 (wraps); next state FETCH if run=1, else IDLE. run is sampled only at retire and in IDLE.
//  - Timeout: counter cleared on entry to FETCH/MEM_RD/MEM_WR; +1 per cycle with mem_ready=0.
//      If the MEM_TIMEOUT-th waiting cycle still has mem_ready=0 ->TRAP, cause 10.
//      mem_ready in that cycle wins (normal transition).
//  - TRAP: trap=1, trap_cause held, all other controls 0, instret frozen. Left only by reset.
//  - Latency (zero-wait memory): R/I/U/store 4 cycles; load 5; branch/jal/jalr 3.
// TESTING
//  1. run=1, ADD (0110011), mem_ready=1 -> state_o 1,2,3,9,1; reg_write=1, wb_sel=00 only in state 9; instret=1.
//  2. LW, mem_ready delayed 3 cycles in MEM_RD -> mem_req high 4 cycles, mem_we=0; WB_MEM wb_sel=01; 8 cycles total.
//  3. BEQ funct3=000: zero=1 -> pc_write=1, pc_src=01; zero=0 -> pc_write=0.
//     BNE inverts. funct3=100 -> TRAP, cause 01.
//  4. opcode 1111111 -> state_o=14, trap=1, cause=01; instret unchanged; stays 14 for 20 cycles with run=1.
//  5. MEM_TIMEOUT=4, mem_ready=0 in FETCH -> TRAP cause 10 after 4 waiting cycles.
//     Rerun with mem_ready=1 in 4th waiting cycle -> DECODE.
//  6. rst_n=0 mid MEM_RD -> all outputs 0 immediately, state_o=0, instret=0. run=0 at retire -> IDLE.

Source files
------------

// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle main controller for an RV32I core.
// Walks one instruction at a time through fetch / decode / execute / memory /
// writeback, driving the shared-datapath steering signals as Moore decodes of
// the current state. It also counts retired instructions and parks in a sticky
// trap state on an illegal opcode or on a memory handshake that never completes.
module rv32i_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_op,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic [3:0]       state_o,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_EXEC_R   = 4'd3;
  localparam logic [3:0] S_EXEC_I   = 4'd4;
  localparam logic [3:0] S_EXEC_U   = 4'd5;
  localparam logic [3:0] S_MEM_ADDR = 4'd6;
  localparam logic [3:0] S_MEM_RD   = 4'd7;
  localparam logic [3:0] S_MEM_WR   = 4'd8;
  localparam logic [3:0] S_WB_ALU   = 4'd9;
  localparam logic [3:0] S_WB_MEM   = 4'd10;
  localparam logic [3:0] S_BRANCH   = 4'd11;
  localparam logic [3:0] S_JAL      = 4'd12;
  localparam logic [3:0] S_JALR     = 4'd13;
  localparam logic [3:0] S_TRAP     = 4'd14;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_BUS     = 2'b10;

  // Wait counter holds 0..MEM_TIMEOUT-1; the last value marks the final allowed wait.
  localparam int             TW       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(MEM_TIMEOUT - 1);
  localparam logic [TW-1:0]  TMO_ONE  = TW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0]       state_r;
  logic [3:0]       state_nxt_s;
  logic [TW-1:0]    tmo_r;
  logic [TW-1:0]    tmo_nxt_s;
  logic [1:0]       cause_r;
  logic [1:0]       cause_nxt_s;
  logic [CNT_W-1:0] instret_r;
  logic             retire_s;
  logic [3:0]       after_retire_s;
  logic             tmo_last_s;

  // Conditional branch outcome: BEQ takes on zero, BNE on non-zero.
  function automatic logic branch_taken(input logic [2:0] f3, input logic z);
    return ((f3 == 3'b000) && z) || ((f3 == 3'b001) && !z);
  endfunction

  assign after_retire_s = run ? S_FETCH : S_IDLE;
  assign tmo_last_s     = (tmo_r == TMO_LAST);

  // Next-state, wait-counter, trap-cause and retire decisions.
  always_comb begin
    state_nxt_s = state_r;
    tmo_nxt_s   = {TW{1'b0}};
    cause_nxt_s = cause_r;
    retire_s    = 1'b0;
    case (state_r)
      S_IDLE: state_nxt_s = run ? S_FETCH : S_IDLE;
      S_FETCH: begin
        if (mem_ready) begin
          state_nxt_s = S_DECODE;
        end else if (tmo_last_s) begin
          state_nxt_s = S_TRAP;
          cause_nxt_s = CAUSE_BUS;
        end else begin
          tmo_nxt_s = tmo_r + TMO_ONE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_R:              state_nxt_s = S_EXEC_R;
          OP_I:              state_nxt_s = S_EXEC_I;
          OP_LUI, OP_AUIPC:  state_nxt_s = S_EXEC_U;
          OP_LOAD, OP_STORE: state_nxt_s = S_MEM_ADDR;
          OP_BRANCH: begin
            if ((funct3 == 3'b000) || (funct3 == 3'b001)) begin
              state_nxt_s = S_BRANCH;
            end else begin
              state_nxt_s = S_TRAP;
              cause_nxt_s = CAUSE_ILLEGAL;
            end
          end
          OP_JAL:  state_nxt_s = S_JAL;
          OP_JALR: state_nxt_s = S_JALR;
          default: begin
            state_nxt_s = S_TRAP;
            cause_nxt_s = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_EXEC_U: state_nxt_s = S_WB_ALU;
      S_MEM_ADDR: state_nxt_s = opcode[5] ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready) begin
          state_nxt_s = S_WB_MEM;
        end else if (tmo_last_s) begin
          state_nxt_s = S_TRAP;
          cause_nxt_s = CAUSE_BUS;
        end else begin
          tmo_nxt_s = tmo_r + TMO_ONE;
        end
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          state_nxt_s = after_retire_s;
          retire_s    = 1'b1;
        end else if (tmo_last_s) begin
          state_nxt_s = S_TRAP;
          cause_nxt_s = CAUSE_BUS;
        end else begin
          tmo_nxt_s = tmo_r + TMO_ONE;
        end
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_JALR: begin
        state_nxt_s = after_retire_s;
        retire_s    = 1'b1;
      end
      S_TRAP:  state_nxt_s = S_TRAP;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State, wait counter, trap cause and retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      tmo_r     <= {TW{1'b0}};
      cause_r   <= 2'b00;
      instret_r <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      tmo_r     <= tmo_nxt_s;
      cause_r   <= cause_nxt_s;
      instret_r <= retire_s ? (instret_r + CNT_ONE) : instret_r;
    end
  end

  // Datapath steering decoded from the current state (Mealy only for the handshake and branch).
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    alu_op    = 2'b00;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    reg_write = 1'b0;
    wb_sel    = 2'b00;
    case (state_r)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b10;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b01;
      S_EXEC_R: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b10;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_EXEC_U: begin
        alu_src_a = opcode[5] ? 2'b10 : 2'b00;
        alu_src_b = 2'b01;
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEM_RD: mem_req = 1'b1;
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      S_WB_ALU: reg_write = 1'b1;
      S_WB_MEM: begin
        reg_write = 1'b1;
        wb_sel    = 2'b01;
      end
      S_BRANCH: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_write  = branch_taken(funct3, zero);
      end
      S_JAL: begin
        reg_write = 1'b1;
        wb_sel    = 2'b10;
        pc_write  = 1'b1;
        pc_src    = 2'b01;
      end
      S_JALR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        reg_write = 1'b1;
        wb_sel    = 2'b10;
        pc_write  = 1'b1;
        pc_src    = 2'b10;
      end
      default: mem_req = 1'b0;
    endcase
  end

  assign state_o    = state_r;
  assign trap       = (state_r == S_TRAP);
  assign trap_cause = cause_r;
  assign instret    = instret_r;

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Self-checking bench for rv32i_multicycle_ctrl. A reference model expands
// each instruction (class, wait counts, branch flag, run at retire) into the
// cycle-by-cycle behaviour the controller must show; tasks replay that trace
// and compare every observable output each cycle.
module tb_rv32i_multicycle_ctrl;

  localparam int TMO = 4;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic [1:0]  alu_op;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic [3:0]  state_o;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] instret;

  rv32i_multicycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct3(funct3),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_op(alu_op),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_write(reg_write),
    .wb_sel(wb_sel), .state_o(state_o), .trap(trap), .trap_cause(trap_cause),
    .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One expected cycle: inputs to apply plus {state, controls, trap, cause, instret}.
  typedef struct {
    logic        rdy;
    logic        zr;
    logic        rn;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [53:0] exp;
  } cyc_t;

  cyc_t        trace[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_instret;
  logic        m_trap;
  logic [1:0]  m_cause;
  logic        m_idle;

  localparam logic [6:0] R_OP = 7'b0110011, I_OP = 7'b0010011, LUI_OP = 7'b0110111;
  localparam logic [6:0] AUIPC_OP = 7'b0010111, LD_OP = 7'b0000011, ST_OP = 7'b0100011;
  localparam logic [6:0] BR_OP = 7'b1100011, JAL_OP = 7'b1101111, JALR_OP = 7'b1100111;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Control bundle: mem_req, mem_we, ir_write, pc_write, pc_src, alu_op, a, b, reg_write, wb_sel.
  function automatic logic [14:0] mk(input logic mrq, input logic mwe, input logic irw,
                                     input logic pcw, input logic [1:0] psrc, input logic [1:0] aop,
                                     input logic [1:0] a, input logic [1:0] b, input logic rw,
                                     input logic [1:0] wb);
    return {mrq, mwe, irw, pcw, psrc, aop, a, b, rw, wb};
  endfunction

  function automatic logic [53:0] obs();
    return {state_o, mem_req, mem_we, ir_write, pc_write, pc_src, alu_op, alu_src_a,
            alu_src_b, reg_write, wb_sel, trap, trap_cause, instret};
  endfunction

  function automatic void push(input logic [3:0] st, input logic rdy, input logic zr,
                               input logic rn, input logic [6:0] op, input logic [2:0] f3,
                               input logic [14:0] ctl);
    cyc_t c;
    c.rdy = rdy; c.zr = zr; c.rn = rn; c.op = op; c.f3 = f3;
    c.exp = {st, ctl, m_trap, m_cause, m_instret};
    trace.push_back(c);
  endfunction

  function automatic void retire(input logic rr);
    m_instret = m_instret + 32'd1;
    m_idle    = !rr;
  endfunction

  function automatic void enter_trap(input logic [1:0] cause, input logic [6:0] op,
                                     input logic [2:0] f3);
    m_trap  = 1'b1;
    m_cause = cause;
    for (int k = 0; k < 3; k++) push(4'd14, rb(), rb(), rb(), op, f3, 15'd0);
  endfunction

  // Handshake phase: w waiting cycles, then the ready cycle, unless w reaches the timeout.
  function automatic bit mem_phase(input logic [3:0] st, input int w, input logic [6:0] op,
                                   input logic [2:0] f3, input logic [14:0] ctl_w,
                                   input logic [14:0] ctl_ok, input logic rn_ok, input bit ret);
    for (int k = 0; k < w && k < TMO; k++) push(st, 1'b0, rb(), rb(), op, f3, ctl_w);
    if (w >= TMO) begin
      enter_trap(2'b10, op, f3);
      return 1'b0;
    end
    push(st, 1'b1, rb(), rn_ok, op, f3, ctl_ok);
    if (ret) retire(rn_ok);
    return 1'b1;
  endfunction

  // Expand one instruction into its expected cycles.
  function automatic void model_instr(input logic [6:0] op, input logic [2:0] f3, input logic zr,
                                      input int fw, input int mw, input logic rr);
    logic pw;
    if (m_trap) return;
    if (m_idle) begin
      push(4'd0, rb(), rb(), 1'b1, op, f3, 15'd0);
      m_idle = 1'b0;
    end
    if (!mem_phase(4'd1, fw, op, f3, mk(1,0,0,0,2'd0,2'd0,2'd0,2'd2,0,2'd0),
                   mk(1,0,1,1,2'd0,2'd0,2'd0,2'd2,0,2'd0), rb(), 1'b0)) return;
    push(4'd2, rb(), rb(), rb(), op, f3, mk(0,0,0,0,2'd0,2'd0,2'd0,2'd1,0,2'd0));
    case (op)
      R_OP, I_OP, LUI_OP, AUIPC_OP: begin
        if (op == R_OP)
          push(4'd3, rb(), rb(), rb(), op, f3, mk(0,0,0,0,2'd0,2'd2,2'd1,2'd0,0,2'd0));
        else if (op == I_OP)
          push(4'd4, rb(), rb(), rb(), op, f3, mk(0,0,0,0,2'd0,2'd2,2'd1,2'd1,0,2'd0));
        else
          push(4'd5, rb(), rb(), rb(), op, f3,
               mk(0,0,0,0,2'd0,2'd0,(op == LUI_OP) ? 2'd2 : 2'd0,2'd1,0,2'd0));
        push(4'd9, rb(), rb(), rr, op, f3, mk(0,0,0,0,2'd0,2'd0,2'd0,2'd0,1,2'd0));
        retire(rr);
      end
      LD_OP: begin
        push(4'd6, rb(), rb(), rb(), op, f3, mk(0,0,0,0,2'd0,2'd0,2'd1,2'd1,0,2'd0));
        if (mem_phase(4'd7, mw, op, f3, mk(1,0,0,0,2'd0,2'd0,2'd0,2'd0,0,2'd0),
                      mk(1,0,0,0,2'd0,2'd0,2'd0,2'd0,0,2'd0), rb(), 1'b0)) begin
          push(4'd10, rb(), rb(), rr, op, f3, mk(0,0,0,0,2'd0,2'd0,2'd0,2'd0,1,2'd1));
          retire(rr);
        end
      end
      ST_OP: begin
        push(4'd6, rb(), rb(), rb(), op, f3, mk(0,0,0,0,2'd0,2'd0,2'd1,2'd1,0,2'd0));
        void'(mem_phase(4'd8, mw, op, f3, mk(1,1,0,0,2'd0,2'd0,2'd0,2'd0,0,2'd0),
                        mk(1,1,0,0,2'd0,2'd0,2'd0,2'd0,0,2'd0), rr, 1'b1));
      end
      BR_OP: begin
        if (f3 == 3'd0 || f3 == 3'd1) begin
          pw = (f3 == 3'd0) ? zr : !zr;
          push(4'd11, rb(), zr, rr, op, f3, mk(0,0,0,pw,2'd1,2'd1,2'd1,2'd0,0,2'd0));
          retire(rr);
        end else begin
          enter_trap(2'b01, op, f3);
        end
      end
      JAL_OP: begin
        push(4'd12, rb(), rb(), rr, op, f3, mk(0,0,0,1,2'd1,2'd0,2'd0,2'd0,1,2'd2));
        retire(rr);
      end
      JALR_OP: begin
        push(4'd13, rb(), rb(), rr, op, f3, mk(0,0,0,1,2'd2,2'd0,2'd1,2'd1,1,2'd2));
        retire(rr);
      end
      default: enter_trap(2'b01, op, f3);
    endcase
  endfunction

  task automatic apply(input cyc_t c);
    @(negedge clk);
    mem_ready = c.rdy; zero = c.zr; run = c.rn; opcode = c.op; funct3 = c.f3;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = 7'd0; funct3 = 3'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_instret = 32'd0; m_trap = 1'b0; m_cause = 2'b00; m_idle = 1'b1;
    trace.delete();
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 54'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h expected %h", obs(), 54'd0);
    end
    rst_n = 1'b1;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (obs() !== 54'd0) begin
      n_fail++;
      $display("FAIL idle_run_low: got %h expected %h", obs(), 54'd0);
    end
  endtask

  task automatic test_add();
    do_reset();
    model_instr(R_OP, 3'd0, 1'b0, 0, 0, 1'b1);
    model_instr(I_OP, 3'd0, 1'b0, 0, 0, 1'b1);
    foreach (trace[i]) begin
      apply(trace[i]);
      n_checks++;
      if (obs() !== trace[i].exp) begin
        n_fail++;
        $display("FAIL add cycle %0d: got %h expected %h", i, obs(), trace[i].exp);
      end
    end
    trace.delete();
  endtask

  task automatic test_load_wait();
    do_reset();
    model_instr(LD_OP, 3'd2, 1'b0, 0, 3, 1'b1);
    model_instr(ST_OP, 3'd2, 1'b0, 1, 2, 1'b1);
    model_instr(LUI_OP, 3'd0, 1'b0, 0, 0, 1'b1);
    model_instr(AUIPC_OP, 3'd0, 1'b0, 0, 0, 1'b0);
    foreach (trace[i]) begin
      apply(trace[i]);
      n_checks++;
      if (obs() !== trace[i].exp) begin
        n_fail++;
        $display("FAIL load_store cycle %0d: got %h expected %h", i, obs(), trace[i].exp);
      end
    end
    trace.delete();
  endtask

  task automatic test_branch();
    do_reset();
    model_instr(BR_OP, 3'd0, 1'b1, 0, 0, 1'b1);
    model_instr(BR_OP, 3'd0, 1'b0, 0, 0, 1'b1);
    model_instr(BR_OP, 3'd1, 1'b1, 0, 0, 1'b1);
    model_instr(BR_OP, 3'd1, 1'b0, 0, 0, 1'b1);
    model_instr(JAL_OP, 3'd0, 1'b0, 0, 0, 1'b1);
    model_instr(JALR_OP, 3'd0, 1'b0, 0, 0, 1'b1);
    model_instr(BR_OP, 3'd4, 1'b1, 0, 0, 1'b1);
    foreach (trace[i]) begin
      apply(trace[i]);
      n_checks++;
      if (obs() !== trace[i].exp) begin
        n_fail++;
        $display("FAIL branch cycle %0d: got %h expected %h", i, obs(), trace[i].exp);
      end
    end
    trace.delete();
  endtask

  task automatic test_illegal();
    do_reset();
    model_instr(R_OP, 3'd0, 1'b0, 0, 0, 1'b1);
    model_instr(7'b1111111, 3'd0, 1'b0, 0, 0, 1'b1);
    for (int k = 0; k < 20; k++) push(4'd14, rb(), rb(), 1'b1, 7'b1111111, 3'd0, 15'd0);
    foreach (trace[i]) begin
      apply(trace[i]);
      n_checks++;
      if (obs() !== trace[i].exp) begin
        n_fail++;
        $display("FAIL illegal cycle %0d: got %h expected %h", i, obs(), trace[i].exp);
      end
    end
    trace.delete();
  endtask

  task automatic test_timeout();
    for (int pass = 0; pass < 3; pass++) begin
      do_reset();
      if (pass == 0) model_instr(R_OP, 3'd0, 1'b0, TMO, 0, 1'b1);
      if (pass == 1) model_instr(R_OP, 3'd0, 1'b0, TMO - 1, 0, 1'b1);
      if (pass == 2) model_instr(LD_OP, 3'd0, 1'b0, TMO - 1, TMO, 1'b1);
      model_instr(I_OP, 3'd0, 1'b0, 0, 0, 1'b1);
      foreach (trace[i]) begin
        apply(trace[i]);
        n_checks++;
        if (obs() !== trace[i].exp) begin
          n_fail++;
          $display("FAIL timeout pass %0d cycle %0d: got %h expected %h",
                   pass, i, obs(), trace[i].exp);
        end
      end
      trace.delete();
    end
  endtask

  task automatic test_reset_mid_and_run_low();
    int n_rd;
    do_reset();
    model_instr(R_OP, 3'd0, 1'b0, 0, 0, 1'b1);
    model_instr(LD_OP, 3'd0, 1'b0, 0, 3, 1'b1);
    n_rd = 0;
    foreach (trace[i]) begin
      apply(trace[i]);
      n_checks++;
      if (obs() !== trace[i].exp) begin
        n_fail++;
        $display("FAIL reset_mid cycle %0d: got %h expected %h", i, obs(), trace[i].exp);
      end
      if (trace[i].exp[53:50] == 4'd7) n_rd++;
      if (n_rd == 2) break;
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 54'd0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %h expected %h", obs(), 54'd0);
    end
    do_reset();
    model_instr(R_OP, 3'd0, 1'b0, 0, 0, 1'b0);
    for (int k = 0; k < 3; k++) push(4'd0, rb(), rb(), 1'b0, R_OP, 3'd0, 15'd0);
    model_instr(JAL_OP, 3'd0, 1'b0, 0, 0, 1'b0);
    model_instr(I_OP, 3'd0, 1'b0, 0, 0, 1'b1);
    foreach (trace[i]) begin
      apply(trace[i]);
      n_checks++;
      if (obs() !== trace[i].exp) begin
        n_fail++;
        $display("FAIL run_low cycle %0d: got %h expected %h", i, obs(), trace[i].exp);
      end
    end
    trace.delete();
  endtask

  function automatic bit is_legal_op(input logic [6:0] op);
    return (op == R_OP) || (op == I_OP) || (op == LUI_OP) || (op == AUIPC_OP) ||
           (op == LD_OP) || (op == ST_OP) || (op == BR_OP) || (op == JAL_OP) ||
           (op == JALR_OP);
  endfunction

  task automatic test_random();
    logic [6:0] op;
    logic [2:0] f3;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 8))
        0: op = R_OP;   1: op = I_OP;   2: op = LUI_OP;
        3: op = AUIPC_OP; 4: op = LD_OP; 5: op = ST_OP;
        6: op = BR_OP;  7: op = JAL_OP; default: op = JALR_OP;
      endcase
      f3 = (op == BR_OP) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
      model_instr(op, f3, rb(), $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1),
                  ($urandom_range(0, 3) != 0));
    end
    op = 7'($urandom_range(0, 127));
    while (is_legal_op(op)) op = 7'($urandom_range(0, 127));
    model_instr(op, 3'($urandom_range(0, 7)), rb(), 0, 0, 1'b1);
    foreach (trace[i]) begin
      apply(trace[i]);
      n_checks++;
      if (obs() !== trace[i].exp) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %h expected %h", i, obs(), trace[i].exp);
      end
    end
    trace.delete();
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_wait();
    test_branch();
    test_illegal();
    test_timeout();
    test_reset_mid_and_run_low();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
